// File: rtl/line_rotator_pkg.sv
//------------------------------------------------------------------------------
// Module   : line_rotator_pkg
// Purpose  : Shared constants and FSM state encoding for the line rotator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package line_rotator_pkg;

    localparam int MEMSIZE  = 25;
    localparam int CNTW     = 6;
    localparam int LINE_MOD = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        ROTATE = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rot_amount_counter.sv
//------------------------------------------------------------------------------
// Module   : rot_amount_counter
// Purpose  : Rotation-amount register with load, subtract-LINE_MOD and
//            decrement controls, plus >=LINE_MOD and zero flags.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rot_amount_counter #(
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [CNTW-1:0] i_load_val,
    input  logic            i_sub,
    input  logic            i_dec,
    output logic [CNTW-1:0] o_amt,
    output logic            o_ge_mod,
    output logic            o_zero
);
    import line_rotator_pkg::*;

    localparam logic [CNTW-1:0] c_line_mod = CNTW'(LINE_MOD);

    logic [CNTW-1:0] r_amt;
    logic            w_ge_mod;
    logic            w_zero;

    assign w_ge_mod = (r_amt >= c_line_mod);
    assign w_zero   = (r_amt == '0);

    // Each step is guarded by its flag so the register can never wrap below 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_amt <= '0;
        end else if (i_load) begin
            r_amt <= i_load_val;
        end else if (i_sub && w_ge_mod) begin
            r_amt <= r_amt - c_line_mod;
        end else if (i_dec && !w_zero) begin
            r_amt <= r_amt - 1'b1;
        end
    end

    assign o_amt    = r_amt;
    assign o_ge_mod = w_ge_mod;
    assign o_zero   = w_zero;

endmodule

`default_nettype wire

// File: rtl/line_rotator.sv
//------------------------------------------------------------------------------
// Module   : line_rotator
// Purpose  : Rotates a MEMSIZE-bit line left or right by count positions,
//            one bit per cycle after reducing count modulo the line length.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module line_rotator #(
    parameter int MEMSIZE = 25,
    parameter int CNTW    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MEMSIZE-1:0] lineIn,
    input  logic [CNTW-1:0]    count,
    input  logic               dir,
    output logic               busy,
    output logic               done,
    output logic [MEMSIZE-1:0] lineOut
);
    import line_rotator_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MEMSIZE-1:0] r_work;
    logic               r_dir;
    logic [MEMSIZE-1:0] r_line_out;

    logic               w_load;
    logic               w_sub;
    logic               w_dec;
    logic               w_out_load;
    logic [CNTW-1:0]    w_amt;
    logic               w_ge_mod;
    logic               w_zero;

    rot_amount_counter #(
        .CNTW (CNTW)
    ) u_amount (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (count),
        .i_sub      (w_sub),
        .i_dec      (w_dec),
        .o_amt      (w_amt),
        .o_ge_mod   (w_ge_mod),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sub       = 1'b0;
        w_dec       = 1'b0;
        w_out_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = REDUCE;
                end
            end
            REDUCE: begin
                if (w_ge_mod) begin
                    w_sub = 1'b1;
                end else begin
                    w_state_nxt = ROTATE;
                end
            end
            ROTATE: begin
                // lineOut is loaded on the way into FINISH so it is valid with done.
                if (!w_zero) begin
                    w_dec = 1'b1;
                end else begin
                    w_out_load  = 1'b1;
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_work <= '0;
            r_dir  <= 1'b0;
        end else if (w_load) begin
            r_work <= lineIn;
            r_dir  <= dir;
        end else if (w_dec) begin
            if (r_dir) begin
                r_work <= {r_work[0], r_work[MEMSIZE-1:1]};
            end else begin
                r_work <= {r_work[MEMSIZE-2:0], r_work[MEMSIZE-1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_line_out <= '0;
        end else if (w_out_load) begin
            r_line_out <= r_work;
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == FINISH);
    assign lineOut = r_line_out;

endmodule

`default_nettype wire

// File: tb/tb_line_rotator.sv
//------------------------------------------------------------------------------
// Module   : tb_line_rotator
// Purpose  : Directed, scoreboard-based self-checking bench for line_rotator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_rotator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [24:0] lineIn;
    logic [5:0]  count;
    logic        dir;
    logic        busy;
    logic        done;
    logic [24:0] lineOut;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [24:0] line;
        int          lat;
    } exp_t;

    exp_t sb[$];

    line_rotator #(
        .MEMSIZE (25),
        .CNTW    (6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .lineIn  (lineIn),
        .count   (count),
        .dir     (dir),
        .busy    (busy),
        .done    (done),
        .lineOut (lineOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] model(input logic [24:0] l, input int c, input bit d);
        logic [24:0] v;
        v = l;
        for (int i = 0; i < (c % 25); i++) begin
            v = d ? {v[0], v[24:1]} : {v[23:0], v[24]};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [24:0] line, input logic [5:0] cnt, input logic d);
        exp_t e;
        @(negedge clk);
        lineIn = line;
        count  = cnt;
        dir    = d;
        start  = 1'b1;
        e.line = model(line, int'(cnt), d);
        e.lat  = int'(cnt) / 25 + int'(cnt) % 25 + 2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        lineIn = 25'($urandom);
        count  = 6'($urandom);
        dir    = 1'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic expect_done(input int restart_at, input bit poke_finish);
        exp_t e;
        int   lat;
        bit   seen;
        seen = 1'b0;
        lat  = 0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            lat = k;
            if (restart_at != 0 && k == restart_at - 1) begin
                start  = 1'b1;
                lineIn = 25'h1FFFFFF;
                count  = 6'd7;
                dir    = 1'b1;
            end
            if (restart_at != 0 && k == restart_at) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("busy_running", {31'd0, busy}, 32'd1);
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency", lat, e.lat);
        chk("lineOut", {7'd0, lineOut}, {7'd0, e.line});
        chk("busy_finish", {31'd0, busy}, 32'd1);
        if (poke_finish) begin
            start  = 1'b1;
            lineIn = 25'h0ABCDEF;
            count  = 6'd4;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_after", {31'd0, busy}, 32'd0);
        chk("lineOut_held", {7'd0, lineOut}, {7'd0, e.line});
    endtask

    initial begin
        int done_cnt;
        rst    = 1'b0;
        start  = 1'b0;
        lineIn = '0;
        count  = '0;
        dir    = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_lineOut", {7'd0, lineOut}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        launch(25'h0000001, 6'd3, 1'b0);
        expect_done(0, 1'b0);
        launch(25'h0000001, 6'd1, 1'b1);
        expect_done(0, 1'b0);
        launch(25'h15A5A5A, 6'd50, 1'b0);
        expect_done(0, 1'b1);
        // back-to-back start in the IDLE cycle right after FINISH
        launch(25'h0000001, 6'd63, 1'b0);
        expect_done(0, 1'b0);
        launch(25'h1234567, 6'd0, 1'b1);
        expect_done(0, 1'b0);
        launch(25'h0F0F0F0, 6'd25, 1'b1);
        expect_done(0, 1'b0);

        // second start while busy is ignored
        launch(25'h0000005, 6'd20, 1'b0);
        expect_done(4, 1'b0);

        for (int i = 0; i < 4; i++) begin
            launch(25'($urandom), 6'($urandom), 1'($urandom));
            expect_done(0, 1'b0);
        end

        // reset in the middle of an operation
        launch(25'h0000011, 6'd10, 1'b0);
        void'(sb.pop_back());
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_lineOut", {7'd0, lineOut}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 32'd0);
        chk("abort_lineOut_after", {7'd0, lineOut}, 32'd0);

        launch(25'h0000003, 6'd2, 1'b0);
        chk("fresh_model", {7'd0, sb[0].line}, 32'h0000000C);
        expect_done(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/line_rotator.md
LINE_ROTATOR -- requirements
Module: line_rotator

Interface
REQ-001 The block SHALL have parameter MEMSIZE, default 25, the line width in bits.
REQ-002 The block SHALL have parameter CNTW, default 6, the rotation-count width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-005 Port: rst  in  1  asynchronous reset, active-low.
REQ-006 Port: start  in  1  request; sampled only in IDLE.
REQ-007 Port: lineIn  in  MEMSIZE  line to rotate; captured with start.
REQ-008 Port: count  in  CNTW  rotation amount, 0..63; captured with start.
REQ-009 Port: dir  in  1  direction: 0 = rotate left (toward MSB), 1 = rotate right; captured with start.
REQ-010 Port: busy  out  1  high whenever the state is not IDLE.
REQ-011 Port: done  out  1  one-cycle pulse; the result is valid on lineOut.
REQ-012 Port: lineOut  out  MEMSIZE  last rotated line; held until the next completion.

Function
REQ-013 The FSM SHALL have the states IDLE, REDUCE, ROTATE and FINISH.
REQ-014 IDLE: when start=1, the block SHALL capture lineIn into the work register, count into amt and dir into dirReg, then go to REDUCE; otherwise it stays in IDLE.
REQ-015 REDUCE: if amt>=25, the block SHALL set amt=amt-25 and stay; otherwise it SHALL go to ROTATE (at most 3 cycles for count<=63).
REQ-016 ROTATE: if amt!=0, the block SHALL rotate the work register by 1 in direction dirReg, decrement amt and stay; otherwise it SHALL go to FINISH.
REQ-017 A left rotate by 1 SHALL give {w[MEMSIZE-2:0], w[MEMSIZE-1]}; a right rotate by 1 SHALL give {w[0], w[MEMSIZE-1:1]}.
REQ-018 FINISH: the block SHALL load lineOut from the work register, assert done for exactly this one cycle, then return to IDLE.
REQ-019 Latency: with q=floor(count/25) and r=count mod 25, done SHALL be high in the cycle that begins q+r+2 rising edges after the edge that sampled start.
REQ-020 A start asserted while busy=1, including during FINISH, SHALL be ignored and SHALL NOT be queued.
REQ-021 lineIn, count and dir changing while busy=1 SHALL NOT affect the operation in progress.
REQ-022 count=0, 25 or 50 SHALL produce lineOut equal to the captured line.
REQ-023 The amt register SHALL be CNTW bits wide, and subtraction SHALL never underflow (guarded by amt>=25).
REQ-024 Back-to-back: a start in the IDLE cycle right after FINISH SHALL be accepted.

Reset
REQ-025 When rst=0, the block SHALL immediately force IDLE, busy=0, done=0, lineOut=0, amt=0, dirReg=0 and work register=0.
REQ-026 A reset during REDUCE or ROTATE SHALL abort the operation: no done pulse, and lineOut=0.
REQ-027 After rst is released, the first rising edge SHALL evaluate start in IDLE.

Structure
REQ-028 The shared package SHALL hold the state encoding (IDLE=2'd0, REDUCE=2'd1, ROTATE=2'd2, FINISH=2'd3), MEMSIZE=25, CNTW=6 and the constant LINE_MOD=25.
REQ-029 The amount logic SHALL be one sub-module, rot_amount_counter: a CNTW-bit register with load, subtract-LINE_MOD and decrement controls, plus ge25 and zero flags.
REQ-030 The rotator datapath and FSM SHALL sit in line_rotator; the design SHALL use no multi-bit barrel shifter.

Verification
REQ-031 lineIn=25'h0000001, count=3, dir=0 -> lineOut=25'h0000008; done 5 edges after the start edge; busy high from the start edge until FINISH completes.
REQ-032 lineIn=25'h0000001, count=1, dir=1 -> lineOut=25'h1000000; done 3 edges after the start edge.
REQ-033 lineIn=25'h15A5A5A, count=50, dir=0 -> lineOut=25'h15A5A5A; done 4 edges after the start edge. count=63, lineIn=25'h0000001, dir=0 -> lineOut=25'h0002000; done 17 edges after the start edge.
REQ-034 Start with count=20, then pulse start again plus new lineIn/count at edge +4 -> the second request is ignored; a single done at edge +22 carries the first result.
REQ-035 Start with count=10, assert rst=0 at edge +6 for 2 cycles -> busy=0, lineOut=0 and no done; a fresh start afterwards with count=2, lineIn=25'h0000003, dir=0 -> 25'h000000C.
